divider_arbiter: RTL and testbench
==================================

# divider_arbiter

Sequential front-end that shares one combinational `Four_Bit_Divider` between two requesters. It arbitrates round-robin and registers the winning operands into the divider. It waits a programmable settling time, captures quotient/remainder and returns the result over a valid/ready response channel tagged with the requester ID. Divide-by-zero is detected locally and flagged, never passed as a result from the divider.

## Interface
Parameters:
- `DIV_LATENCY`, default 1: cycles operands are held stable at the divider before capture; legal range 1–7.

Ports:
- `Clock`  input  1  single clock, all state updates on rising edge.
- `Reset`  input  1  synchronous, active-low; one clock, reset is synchronous and active-low.
- `Req_Valid`  input  2  bit i: requester i presents an operation.
- `Req_Ready`  output  2  bit i: controller accepts requester i this cycle.
- `Dividend0`, `Divisor0`  input  4 each  requester 0 operands.
- `Dividend1`, `Divisor1`  input  4 each  requester 1 operands.
- `Rsp_Valid`  output  1  response available.
- `Rsp_Ready`  input  1  consumer accepts response.
- `Rsp_Id`  output  1  requester that owns the response.
- `Quotient`, `Remainder`  output  4 each  registered result.
- `Div_By_Zero`  output  1  response was for `Divisor == 0`.

## Operation
- FSM states: IDLE, WAIT, RESPOND.
- **IDLE**
  - Grant goes to a requester with `Req_Valid`; if both are valid, to the one selected by the round-robin pointer `Rr_Ptr`.
  - `Req_Ready` is one-hot for the granted requester, 0 otherwise.
  - On handshake: latch operands into `Op_Dividend`/`Op_Divisor`, latch `Op_Id`, load `Wait_Cnt = DIV_LATENCY-1`, set `Rr_Ptr = ~Op_Id`, go to WAIT.
- **WAIT**
  - The divider sees the latched operands.
  - `Wait_Cnt` decrements each cycle.
  - When `Wait_Cnt == 0`: capture the divider outputs into `Quotient`/`Remainder`, set `Rsp_Valid`, go to RESPOND.
  - If `Op_Divisor == 0`: capture `Quotient = 4'hF`, `Remainder = Op_Dividend`, `Div_By_Zero = 1` instead of divider outputs.
- **RESPOND**
  - Outputs are held stable while `Rsp_Valid && !Rsp_Ready`.
  - On `Rsp_Ready`: clear `Rsp_Valid`, go to IDLE.
- `Req_Ready` is 0 in WAIT and RESPOND. Only one operation is in flight; there is no queuing.
- Divider `Reset` pin is driven to 1 whenever the controller is out of reset and to 0 during controller reset.
- Requester inputs are sampled only on the handshake edge; changes afterwards do not affect the in-flight operation.

## Timing
- Reset values while `Reset == 0` at a clock edge:
  - state IDLE, `Req_Ready = 2'b00`, `Rsp_Valid = 0`, `Rsp_Id = 0`;
  - `Quotient = 0`, `Remainder = 0`, `Div_By_Zero = 0`;
  - `Rr_Ptr = 0`, `Wait_Cnt = 0`, operand registers 0.
- `Req_Ready` is combinational from state, `Req_Valid` and `Rr_Ptr`. All other outputs are registered.
- Latency: with the handshake at edge k, `Rsp_Valid` rises after edge k+DIV_LATENCY.
- Earliest next acceptance is the edge after the `Rsp_Ready` handshake, since `Req_Ready` is only asserted in IDLE. No response/request overlap.
- Round-robin: after a grant to requester i, the next simultaneous request goes to requester 1-i. A single valid requester always wins regardless of `Rr_Ptr`.
- Reset asserted mid-operation in WAIT or RESPOND: the operation is discarded, no response is issued, and all values return to reset values on that edge.
- `Req_Valid` deasserted before the handshake: no acceptance, stay in IDLE. The requester is not required to hold `Req_Valid` (no protocol assertion).

## Structure
- Shared package `divider_pkg`:
  - state enum `DIV_IDLE`/`DIV_WAIT`/`DIV_RESPOND`;
  - constants `DIV_W = 4` and `DBZ_QUOTIENT = 4'hF`.
- One sub-module: the existing `Four_Bit_Divider`, instantiated once and fed from the operand registers.
- Arbitration logic stays inline.

## Test plan
- **Single request:** after reset, requester 0 sends 13/3 with `DIV_LATENCY = 1` → `Rsp_Valid` one cycle after the handshake, `Quotient = 4`, `Remainder = 1`, `Rsp_Id = 0`, `Div_By_Zero = 0`.
- **Contention:** both valid simultaneously, requester 0 with 9/2 and requester 1 with 15/4 → requester 0 is served first (4 r1), then requester 1 (3 r3). A following contention is granted to requester 1 first.
- **Divide-by-zero:** requester 1 sends 14/0 → `Quotient = 15`, `Remainder = 14`, `Div_By_Zero = 1`.
- **Backpressure:** `Rsp_Ready = 0` for 5 cycles on 15/8 → `Quotient = 1`, `Remainder = 7` held constant, `Req_Ready = 0` throughout, IDLE one cycle after `Rsp_Ready` rises.
- **Latency parameter:** `DIV_LATENCY = 4` on 12/7 → `Rsp_Valid` 4 cycles after the handshake, result 1 r5. Operand changes after the handshake are ignored.
- **Reset mid-flight:** `Reset` low during WAIT → no response, all outputs at reset values. The next request after deassertion completes normally.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the divider arbiter and its datapath.
package divider_pkg;

   localparam int unsigned DIV_W = 4;
   localparam int unsigned CNT_W = 3;
   localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 4'hF;

   typedef enum logic [1:0] {
      DIV_IDLE    = 2'd0,
      DIV_WAIT    = 2'd1,
      DIV_RESPOND = 2'd2
   } div_state_t;

endpackage

// File: rtl/Four_Bit_Divider.sv
// Combinational restoring divider; outputs forced to zero while Reset is low.
module Four_Bit_Divider
   import divider_pkg::*;
(
   input  logic             Reset,
   input  logic [DIV_W-1:0] Dividend,
   input  logic [DIV_W-1:0] Divisor,
   output logic [DIV_W-1:0] Quotient,
   output logic [DIV_W-1:0] Remainder
);

   logic [DIV_W:0]   w_rem;
   logic [DIV_W-1:0] w_dvd;
   logic [DIV_W-1:0] w_quo;

   // One restoring step per dividend bit, MSB first.
   always_comb begin
      w_rem = '0;
      w_dvd = Dividend;
      w_quo = '0;
      for (int i = 0; i < int'(DIV_W); i++) begin
         w_rem = {w_rem[DIV_W-1:0], w_dvd[DIV_W-1]};
         w_dvd = {w_dvd[DIV_W-2:0], 1'b0};
         if (w_rem >= {1'b0, Divisor}) begin
            w_rem = w_rem - {1'b0, Divisor};
            w_quo = {w_quo[DIV_W-2:0], 1'b1};
         end else begin
            w_quo = {w_quo[DIV_W-2:0], 1'b0};
         end
      end
   end

   assign Quotient  = Reset ? w_quo : '0;
   assign Remainder = Reset ? w_rem[DIV_W-1:0] : '0;

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front-end sharing one combinational divider between two requesters,
// with programmable settling time and a valid/ready response channel.
module divider_arbiter
   import divider_pkg::*;
#(
   parameter int unsigned DIV_LATENCY = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [1:0]       Req_Valid,
   output logic [1:0]       Req_Ready,
   input  logic [DIV_W-1:0] Dividend0,
   input  logic [DIV_W-1:0] Divisor0,
   input  logic [DIV_W-1:0] Dividend1,
   input  logic [DIV_W-1:0] Divisor1,
   output logic             Rsp_Valid,
   input  logic             Rsp_Ready,
   output logic             Rsp_Id,
   output logic [DIV_W-1:0] Quotient,
   output logic [DIV_W-1:0] Remainder,
   output logic             Div_By_Zero
);

   div_state_t       r_state, w_state_nxt;
   logic             r_rr_ptr, w_rr_ptr_nxt;
   logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
   logic [DIV_W-1:0] r_op_dividend, w_op_dividend_nxt;
   logic [DIV_W-1:0] r_op_divisor, w_op_divisor_nxt;
   logic             r_op_id, w_op_id_nxt;
   logic             r_rsp_valid, w_rsp_valid_nxt;
   logic             r_rsp_id, w_rsp_id_nxt;
   logic [DIV_W-1:0] r_quotient, w_quotient_nxt;
   logic [DIV_W-1:0] r_remainder, w_remainder_nxt;
   logic             r_dbz, w_dbz_nxt;
   logic [1:0]       w_grant;
   logic             w_gid;
   logic [DIV_W-1:0] w_div_q;
   logic [DIV_W-1:0] w_div_r;

   Four_Bit_Divider u_divider (
      .Reset     (Reset),
      .Dividend  (r_op_dividend),
      .Divisor   (r_op_divisor),
      .Quotient  (w_div_q),
      .Remainder (w_div_r)
   );

   // Next-state, arbitration and capture logic.
   always_comb begin
      w_state_nxt       = r_state;
      w_rr_ptr_nxt      = r_rr_ptr;
      w_wait_cnt_nxt    = r_wait_cnt;
      w_op_dividend_nxt = r_op_dividend;
      w_op_divisor_nxt  = r_op_divisor;
      w_op_id_nxt       = r_op_id;
      w_rsp_valid_nxt   = r_rsp_valid;
      w_rsp_id_nxt      = r_rsp_id;
      w_quotient_nxt    = r_quotient;
      w_remainder_nxt   = r_remainder;
      w_dbz_nxt         = r_dbz;
      w_grant           = 2'b00;
      w_gid             = 1'b0;

      case (r_state)
         DIV_IDLE: begin
            if (Req_Valid == 2'b11) w_grant = r_rr_ptr ? 2'b10 : 2'b01;
            else                    w_grant = Req_Valid;
            w_gid = w_grant[1];
            if (w_grant != 2'b00) begin
               w_op_dividend_nxt = w_gid ? Dividend1 : Dividend0;
               w_op_divisor_nxt  = w_gid ? Divisor1  : Divisor0;
               w_op_id_nxt       = w_gid;
               w_wait_cnt_nxt    = CNT_W'(DIV_LATENCY - 1);
               w_rr_ptr_nxt      = ~w_gid;
               w_state_nxt       = DIV_WAIT;
            end
         end
         DIV_WAIT: begin
            if (r_wait_cnt == '0) begin
               // Zero divisor is answered locally; the divider result is ignored.
               if (r_op_divisor == '0) begin
                  w_quotient_nxt  = DBZ_QUOTIENT;
                  w_remainder_nxt = r_op_dividend;
                  w_dbz_nxt       = 1'b1;
               end else begin
                  w_quotient_nxt  = w_div_q;
                  w_remainder_nxt = w_div_r;
                  w_dbz_nxt       = 1'b0;
               end
               w_rsp_id_nxt    = r_op_id;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = DIV_RESPOND;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt - CNT_W'(1);
            end
         end
         DIV_RESPOND: begin
            if (Rsp_Ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = DIV_IDLE;
            end
         end
         default: begin
            w_state_nxt = DIV_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state       <= DIV_IDLE;
         r_rr_ptr      <= 1'b0;
         r_wait_cnt    <= '0;
         r_op_dividend <= '0;
         r_op_divisor  <= '0;
         r_op_id       <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_id      <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_dbz         <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_rr_ptr      <= w_rr_ptr_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
         r_op_dividend <= w_op_dividend_nxt;
         r_op_divisor  <= w_op_divisor_nxt;
         r_op_id       <= w_op_id_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_id      <= w_rsp_id_nxt;
         r_quotient    <= w_quotient_nxt;
         r_remainder   <= w_remainder_nxt;
         r_dbz         <= w_dbz_nxt;
      end
   end

   // Grant is suppressed while in reset so no requester sees a false accept.
   assign Req_Ready   = Reset ? w_grant : 2'b00;
   assign Rsp_Valid   = r_rsp_valid;
   assign Rsp_Id      = r_rsp_id;
   assign Quotient    = r_quotient;
   assign Remainder   = r_remainder;
   assign Div_By_Zero = r_dbz;

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter: one instance at latency 1, one at latency 4.
module tb_divider_arbiter;

   typedef struct packed {
      logic       id;
      logic [3:0] q;
      logic [3:0] r;
      logic       dbz;
   } rsp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   rsp_t exp_a[$];
   rsp_t exp_b[$];

   logic       a_rst, b_rst;
   logic [1:0] a_rv, a_rr, b_rv, b_rr;
   logic [3:0] a_dd0, a_ds0, a_dd1, a_ds1, b_dd0, b_ds0, b_dd1, b_ds1;
   logic       a_rspv, a_rspr, a_id, a_dbz, b_rspv, b_rspr, b_id, b_dbz;
   logic [3:0] a_q, a_r, b_q, b_r;

   divider_arbiter #(.DIV_LATENCY(1)) u_a (
      .Clock(clk), .Reset(a_rst), .Req_Valid(a_rv), .Req_Ready(a_rr),
      .Dividend0(a_dd0), .Divisor0(a_ds0), .Dividend1(a_dd1), .Divisor1(a_ds1),
      .Rsp_Valid(a_rspv), .Rsp_Ready(a_rspr), .Rsp_Id(a_id),
      .Quotient(a_q), .Remainder(a_r), .Div_By_Zero(a_dbz)
   );

   divider_arbiter #(.DIV_LATENCY(4)) u_b (
      .Clock(clk), .Reset(b_rst), .Req_Valid(b_rv), .Req_Ready(b_rr),
      .Dividend0(b_dd0), .Divisor0(b_ds0), .Dividend1(b_dd1), .Divisor1(b_ds1),
      .Rsp_Valid(b_rspv), .Rsp_Ready(b_rspr), .Rsp_Id(b_id),
      .Quotient(b_q), .Remainder(b_r), .Div_By_Zero(b_dbz)
   );

   function automatic rsp_t mk(input logic id, input logic [3:0] q, input logic [3:0] r,
                               input logic dbz);
      rsp_t t;
      t.id = id; t.q = q; t.r = r; t.dbz = dbz;
      return t;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: compare each accepted response against the head of the scoreboard.
   always @(negedge clk) begin
      if (a_rst && a_rspv && a_rspr) begin
         if (exp_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_unexpected_rsp: got 0x%0h required none", {a_id, a_q, a_r, a_dbz});
         end else begin
            check("a_rsp", 16'({a_id, a_q, a_r, a_dbz}), 16'(exp_a.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (b_rst && b_rspv && b_rspr) begin
         if (exp_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected_rsp: got 0x%0h required none", {b_id, b_q, b_r, b_dbz});
         end else begin
            check("b_rsp", 16'({b_id, b_q, b_r, b_dbz}), 16'(exp_b.pop_front()));
         end
      end
   end

   task automatic a_wait_hs(input logic [1:0] exp_g);
      logic [1:0] g;
      g = 2'b00;
      for (int n = 0; n < 50 && g == 2'b00; n++) begin
         @(negedge clk);
         g = a_rv & a_rr;
      end
      @(posedge clk); #1;
      check("a_grant", 16'(g), 16'(exp_g));
   endtask

   task automatic a_issue(input logic id, input logic [3:0] dd, input logic [3:0] ds,
                          input logic push, input rsp_t e);
      if (id) begin a_dd1 = dd; a_ds1 = ds; end
      else    begin a_dd0 = dd; a_ds0 = ds; end
      if (push) exp_a.push_back(e);
      a_rv[id] = 1'b1;
      a_wait_hs(id ? 2'b10 : 2'b01);
      a_rv[id] = 1'b0;
   endtask

   task automatic a_drain();
      for (int n = 0; n < 50 && exp_a.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      check("a_drained", 16'(exp_a.size()), 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [1:0] g;
      a_rst = 1'b0; b_rst = 1'b0;
      a_rv = 2'b11; b_rv = 2'b00;
      a_dd0 = 4'd1; a_ds0 = 4'd1; a_dd1 = 4'd1; a_ds1 = 4'd1;
      b_dd0 = 4'd0; b_ds0 = 4'd0; b_dd1 = 4'd0; b_ds1 = 4'd0;
      a_rspr = 1'b1; b_rspr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("a_rst_req_ready", 16'(a_rr), 16'd0);
      check("a_rst_rsp_valid", 16'(a_rspv), 16'd0);
      check("a_rst_result", 16'({a_id, a_q, a_r, a_dbz}), 16'd0);
      check("b_rst_rsp_valid", 16'(b_rspv), 16'd0);
      check("b_rst_result", 16'({b_id, b_q, b_r, b_dbz}), 16'd0);
      a_rv = 2'b00;
      a_rst = 1'b1; b_rst = 1'b1;
      @(posedge clk); #1;

      // Single request with latency check.
      a_issue(1'b0, 4'd13, 4'd3, 1'b1, mk(1'b0, 4'd4, 4'd1, 1'b0));
      n = 0;
      while (!a_rspv && n < 20) begin @(posedge clk); #1; n++; end
      check("a_latency", 16'(n), 16'd1);

      // Divide by zero from requester 1.
      a_issue(1'b1, 4'd14, 4'd0, 1'b1, mk(1'b1, 4'hF, 4'd14, 1'b1));

      // Contention: grants alternate 0, 1, 0.
      a_drain();
      a_dd0 = 4'd9; a_ds0 = 4'd2; a_dd1 = 4'd15; a_ds1 = 4'd4;
      exp_a.push_back(mk(1'b0, 4'd4, 4'd1, 1'b0));
      exp_a.push_back(mk(1'b1, 4'd3, 4'd3, 1'b0));
      exp_a.push_back(mk(1'b0, 4'd1, 4'd0, 1'b0));
      a_rv = 2'b11;
      a_wait_hs(2'b01);
      a_dd0 = 4'd7; a_ds0 = 4'd7;
      a_wait_hs(2'b10);
      a_rv[1] = 1'b0;
      a_wait_hs(2'b01);
      a_rv = 2'b00;
      a_drain();

      // Backpressure with a competing request held off until release.
      a_rspr = 1'b0;
      a_issue(1'b0, 4'd15, 4'd8, 1'b1, mk(1'b0, 4'd1, 4'd7, 1'b0));
      a_dd1 = 4'd6; a_ds1 = 4'd3;
      exp_a.push_back(mk(1'b1, 4'd2, 4'd0, 1'b0));
      a_rv[1] = 1'b1;
      n = 0;
      while (!a_rspv && n < 20) begin @(posedge clk); #1; n++; end
      for (int k = 0; k < 5; k++) begin
         check("a_bp_rsp_valid", 16'(a_rspv), 16'd1);
         check("a_bp_hold", 16'({a_id, a_q, a_r, a_dbz}), 16'(mk(1'b0, 4'd1, 4'd7, 1'b0)));
         check("a_bp_req_ready", 16'(a_rr), 16'd0);
         @(posedge clk); #1;
      end
      a_rspr = 1'b1;
      @(posedge clk); #1;
      check("a_idle_after_rsp", 16'(a_rr), 16'b10);
      a_wait_hs(2'b10);
      a_rv[1] = 1'b0;
      a_drain();

      // Reset during WAIT discards the operation.
      a_issue(1'b0, 4'd8, 4'd2, 1'b0, mk(1'b0, 4'd0, 4'd0, 1'b0));
      a_rst = 1'b0;
      a_rv = 2'b01;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("a_midrst_req_ready", 16'(a_rr), 16'd0);
      check("a_midrst_rsp_valid", 16'(a_rspv), 16'd0);
      check("a_midrst_result", 16'({a_id, a_q, a_r, a_dbz}), 16'd0);
      a_rv = 2'b00;
      a_rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("a_postrst_no_rsp", 16'(a_rspv), 16'd0);
      a_issue(1'b0, 4'd5, 4'd2, 1'b1, mk(1'b0, 4'd2, 4'd1, 1'b0));
      a_drain();

      // Latency 4 instance; operand changes after handshake must not matter.
      b_dd0 = 4'd12; b_ds0 = 4'd7;
      exp_b.push_back(mk(1'b0, 4'd1, 4'd5, 1'b0));
      b_rv = 2'b01;
      g = 2'b00;
      for (int k = 0; k < 50 && g == 2'b00; k++) begin @(negedge clk); g = b_rv & b_rr; end
      @(posedge clk); #1;
      check("b_grant", 16'(g), 16'b01);
      b_rv = 2'b00;
      b_dd0 = 4'd3; b_ds0 = 4'd1;
      n = 0;
      while (!b_rspv && n < 20) begin @(posedge clk); #1; n++; end
      check("b_latency", 16'(n), 16'd4);
      for (int k = 0; k < 50 && exp_b.size() != 0; k++) begin @(posedge clk); #1; end
      check("b_drained", 16'(exp_b.size()), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
